addr_decoding: RTL and testbench
================================

ADDR_DECODING -- requirements
Module: addr_decoding

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0500, lowest address of the selected window (inclusive).
REQ-002 Parameter LIMIT_ADDR, default 32'h0000_08FF, highest address of the selected window (inclusive); BASE_ADDR <= LIMIT_ADDR SHALL hold.
REQ-003 Parameter OFS_W, default 10, width of LocalAddr; 2**OFS_W SHALL be >= LIMIT_ADDR-BASE_ADDR+1.
REQ-004 Port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port RST, input, 1, reset, synchronous and active-high.
REQ-006 Port Address, input, 32, byte address to decode.
REQ-007 Port AddrValid, input, 1, qualifies Address this cycle.
REQ-008 Port CS, output, 1, registered chip select, 1 = Address inside window.
REQ-009 Port LocalAddr, output, OFS_W, registered window offset (Address - BASE_ADDR).
REQ-010 Port Misaligned, output, 1, registered flag: selected address not word-aligned.
REQ-011 Port HitCount, output, 16, number of valid accesses that selected the window.

Function
REQ-012 Hit condition SHALL be (Address >= BASE_ADDR) and (Address <= LIMIT_ADDR), unsigned 32-bit compare, both bounds inclusive.
REQ-013 CS SHALL equal the hit condition of the Address sampled at the previous rising edge; latency exactly 1 cycle.
REQ-014 CS SHALL be evaluated regardless of AddrValid; AddrValid affects only HitCount.
REQ-015 When hit, LocalAddr SHALL be the low OFS_W bits of (Address - BASE_ADDR); when not hit, LocalAddr SHALL be 0.
REQ-016 Misaligned SHALL be 1 only when hit and Address[1:0] != 2'b00; 0 otherwise; it SHALL NOT suppress CS.
REQ-017 HitCount SHALL increment by 1 on each edge where AddrValid=1 and hit; it SHALL saturate at 16'hFFFF.
REQ-018 Addresses 0xFFFF_FFFF and 0x0000_0000 SHALL decode like any other value (no wrap-around aliasing).
REQ-019 Outputs SHALL be glitch-free register outputs; no combinational path from Address to any output.

Reset
REQ-020 When RST=1 at a rising edge: CS=0, LocalAddr=0, Misaligned=0, HitCount=0, overriding any concurrent hit.
REQ-021 Reset asserted mid-stream SHALL clear outputs on that edge; decoding resumes on the first edge with RST=0.

Structure
REQ-022 BASE_ADDR/LIMIT_ADDR defaults and the memory-map constants SHALL live in a shared package (addr_map_pkg) reused by other decoders.
REQ-023 The inclusive range compare SHALL be one sub-module, addr_range_cmp (inputs Address, bounds; output hit), combinational.

Verification
REQ-024 RST=1 one cycle with Address=0x0700 -> next edge CS=0, HitCount=0.
REQ-025 Address=0x04FF -> CS=0 one cycle later; Address=0x0500 -> CS=1, LocalAddr=0x000.
REQ-026 Sweep Address 0x04FF,0x05FF,0x06FF,0x07FF,0x08FF,0x0900 every 5 cycles -> CS 0,1,1,1,1,0; LocalAddr for 0x08FF = 0x3FF; Misaligned=1 for 0x05FF..0x08FF.
REQ-027 Address=0x0600 with AddrValid=1 for 3 cycles, then AddrValid=0 -> HitCount=3 and holds; CS stays 1.
REQ-028 Address=0xFFFF_FFFF and 0x0000_0000 -> CS=0, LocalAddr=0, Misaligned=0.
REQ-029 Preload HitCount to 0xFFFF via forced valid hits -> further hits leave 0xFFFF.

Source files
------------

// File: rtl/addr_map_pkg.sv
// Shared memory-map constants for the address decoders: bus widths,
// the default decode window and the hit-counter limits.
package addr_map_pkg;

  localparam int ADDR_W    = 32;
  localparam int HIT_CNT_W = 16;
  localparam int DEF_OFS_W = 10;

  localparam logic [ADDR_W-1:0] DEF_BASE_ADDR  = 32'h0000_0500;
  localparam logic [ADDR_W-1:0] DEF_LIMIT_ADDR = 32'h0000_08FF;

  localparam logic [HIT_CNT_W-1:0] HIT_CNT_MAX = 16'hFFFF;

  // Number of bytes covered by an inclusive [base, limit] window.
  function automatic logic [ADDR_W:0] window_bytes(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] limit);
    return {1'b0, limit} - {1'b0, base} + 1'b1;
  endfunction

endpackage

// File: rtl/addr_decoding_if.sv
// Decoder bus: the address request from the requester and the registered
// decode results returned by the decoder.
interface addr_decoding_if
  import addr_map_pkg::*;
#(
  parameter int OFS_W = DEF_OFS_W
);
  logic [ADDR_W-1:0]    Address;
  logic                 AddrValid;
  logic                 CS;
  logic [OFS_W-1:0]     LocalAddr;
  logic                 Misaligned;
  logic [HIT_CNT_W-1:0] HitCount;

  modport master (
    output Address, AddrValid,
    input  CS, LocalAddr, Misaligned, HitCount
  );

  modport slave (
    input  Address, AddrValid,
    output CS, LocalAddr, Misaligned, HitCount
  );
endinterface

// File: rtl/addr_range_cmp.sv
// Combinational inclusive range compare: hit when BaseAddr <= Address <= LimitAddr.
// Plain unsigned compares, so 0x0000_0000 and 0xFFFF_FFFF need no special case.
module addr_range_cmp
  import addr_map_pkg::*;
(
  input  logic [ADDR_W-1:0] Address,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W-1:0] LimitAddr,
  output logic              hit
);

  assign hit = (Address >= BaseAddr) && (Address <= LimitAddr);

endmodule

// File: rtl/addr_decoding.sv
// Single-window address decoder. Decodes every cycle (AddrValid only
// qualifies the hit counter) and presents chip select, window offset,
// misalignment flag and a saturating hit count, all from registers.
module addr_decoding
  import addr_map_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [ADDR_W-1:0] LIMIT_ADDR = DEF_LIMIT_ADDR,
  parameter int                OFS_W      = DEF_OFS_W
)(
  input  logic            CLK,
  input  logic            RST,
  addr_decoding_if.slave  bus
);

  // Stage 0: combinational decode of the incoming address
  logic                 hit_p0;
  logic                 vld_p0;
  logic [OFS_W-1:0]     ofs_p0;
  logic                 mis_p0;

  // Stage 1: registered outputs
  logic                 cs_p1;
  logic [OFS_W-1:0]     ofs_p1;
  logic                 mis_p1;
  logic [HIT_CNT_W-1:0] cnt_p1;

  function automatic logic [HIT_CNT_W-1:0] sat_inc(input logic [HIT_CNT_W-1:0] v);
    return (v == HIT_CNT_MAX) ? v : v + 1'b1;
  endfunction

  addr_range_cmp u_cmp (
    .Address   (bus.Address),
    .BaseAddr  (BASE_ADDR),
    .LimitAddr (LIMIT_ADDR),
    .hit       (hit_p0)
  );

  assign vld_p0 = bus.AddrValid;

  // Offset and alignment are only meaningful inside the window; force zero outside.
  always_comb begin
    ofs_p0 = '0;
    mis_p0 = 1'b0;
    if (hit_p0) begin
      ofs_p0 = OFS_W'(bus.Address - BASE_ADDR);
      mis_p0 = (bus.Address[1:0] != 2'b00);
    end
  end

  // Register the decode; reset clears everything, including a concurrent hit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_p1  <= 1'b0;
      ofs_p1 <= '0;
      mis_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else begin
      cs_p1  <= hit_p0;
      ofs_p1 <= ofs_p0;
      mis_p1 <= mis_p0;
      if (vld_p0 && hit_p0)
        cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign bus.CS         = cs_p1;
  assign bus.LocalAddr  = ofs_p1;
  assign bus.Misaligned = mis_p1;
  assign bus.HitCount   = cnt_p1;

endmodule

// File: tb/tb_addr_decoding.sv
// Self-checking bench for addr_decoding: a reference model pushes the
// expected registered outputs when stimulus is applied, and each test
// pops and compares them one cycle later.
module tb_addr_decoding;
  import addr_map_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0500;
  localparam logic [31:0] LIMIT = 32'h0000_08FF;

  typedef struct {
    logic        cs;
    logic [9:0]  ofs;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;

  addr_decoding_if #(.OFS_W(10)) bus ();

  addr_decoding #(
    .BASE_ADDR  (BASE),
    .LIMIT_ADDR (LIMIT),
    .OFS_W      (10)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  exp_t        sb[$];
  logic [15:0] model_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Drive one cycle of stimulus, record the model's expectation, advance past the edge.
  task automatic apply(input logic [31:0] addr, input logic valid, input logic rst);
    exp_t        e;
    logic        hit;
    logic [31:0] d;
    bus.Address   = addr;
    bus.AddrValid = valid;
    RST           = rst;
    hit = (addr >= BASE) && (addr <= LIMIT);
    d   = addr - BASE;
    if (rst) begin
      model_cnt = 16'h0000;
      e.cs  = 1'b0;
      e.ofs = 10'h000;
      e.mis = 1'b0;
    end else begin
      if (valid && hit && model_cnt != 16'hFFFF)
        model_cnt = model_cnt + 16'h0001;
      e.cs  = hit;
      e.ofs = hit ? d[9:0] : 10'h000;
      e.mis = hit && (addr[1:0] != 2'b00);
    end
    e.cnt = model_cnt;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    apply(32'h0000_0700, 1'b1, 1'b1);
    apply(32'h0000_0700, 1'b1, 1'b1);
    sb.delete();
    // Remaining expectation equals the state the DUT must show after the second reset edge.
    n_checks++;
    if (bus.CS !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", bus.CS); end
    n_checks++;
    if (bus.HitCount !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt: got %h want 0000", bus.HitCount); end
    n_checks++;
    if (bus.LocalAddr !== 10'h000 || bus.Misaligned !== 1'b0) begin
      n_fail++; $display("FAIL reset_ofs_mis: got ofs=%h mis=%b want 000/0", bus.LocalAddr, bus.Misaligned);
    end
    apply(32'h0000_0700, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (bus.CS !== e.cs || bus.LocalAddr !== e.ofs) begin
      n_fail++; $display("FAIL reset_release: got cs=%b ofs=%h want cs=%b ofs=%h", bus.CS, bus.LocalAddr, e.cs, e.ofs);
    end
  endtask

  task automatic test_boundary();
    exp_t e;
    apply(32'h0000_04FF, 1'b1, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (bus.CS !== 1'b0 || bus.CS !== e.cs) begin n_fail++; $display("FAIL below_base_cs: got %b want 0", bus.CS); end
    apply(32'h0000_0500, 1'b1, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (bus.CS !== 1'b1 || bus.LocalAddr !== 10'h000) begin
      n_fail++; $display("FAIL base_hit: got cs=%b ofs=%h want cs=1 ofs=000", bus.CS, bus.LocalAddr);
    end
    n_checks++;
    if (bus.HitCount !== e.cnt) begin n_fail++; $display("FAIL base_cnt: got %h want %h", bus.HitCount, e.cnt); end
  endtask

  task automatic test_sweep();
    logic [31:0] addrs [6] = '{32'h04FF, 32'h05FF, 32'h06FF, 32'h07FF, 32'h08FF, 32'h0900};
    logic        cs_t  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [9:0]  ofs_t [6] = '{10'h000, 10'h0FF, 10'h1FF, 10'h2FF, 10'h3FF, 10'h000};
    logic        mis_t [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 5; c++) begin
        apply(addrs[i], 1'b0, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (bus.CS !== cs_t[i] || bus.LocalAddr !== ofs_t[i] || bus.Misaligned !== mis_t[i]) begin
          n_fail++;
          $display("FAIL sweep_%h: got cs=%b ofs=%h mis=%b want cs=%b ofs=%h mis=%b",
                   addrs[i], bus.CS, bus.LocalAddr, bus.Misaligned, cs_t[i], ofs_t[i], mis_t[i]);
        end
        n_checks++;
        if (bus.HitCount !== e.cnt) begin n_fail++; $display("FAIL sweep_cnt: got %h want %h", bus.HitCount, e.cnt); end
      end
    end
  endtask

  task automatic test_hitcount();
    exp_t e;
    apply(32'h0000_0600, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      apply(32'h0000_0600, 1'b1, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (bus.HitCount !== e.cnt) begin n_fail++; $display("FAIL count_inc: got %h want %h", bus.HitCount, e.cnt); end
    end
    for (int i = 0; i < 4; i++) begin
      apply(32'h0000_0600, 1'b0, 1'b0);
      void'(sb.pop_front());
      n_checks++;
      if (bus.HitCount !== 16'd3 || bus.CS !== 1'b1) begin
        n_fail++; $display("FAIL count_hold: got cnt=%h cs=%b want cnt=0003 cs=1", bus.HitCount, bus.CS);
      end
    end
  endtask

  task automatic test_extremes();
    logic [31:0] addrs [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0502, 32'h0000_08FC};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      apply(addrs[i], 1'b1, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (bus.CS !== e.cs || bus.LocalAddr !== e.ofs || bus.Misaligned !== e.mis || bus.HitCount !== e.cnt) begin
        n_fail++;
        $display("FAIL extreme_%h: got cs=%b ofs=%h mis=%b cnt=%h want cs=%b ofs=%h mis=%b cnt=%h",
                 addrs[i], bus.CS, bus.LocalAddr, bus.Misaligned, bus.HitCount, e.cs, e.ofs, e.mis, e.cnt);
      end
    end
  endtask

  task automatic test_midstream_reset();
    exp_t e;
    apply(32'h0000_0701, 1'b1, 1'b0);
    void'(sb.pop_front());
    apply(32'h0000_0701, 1'b1, 1'b1);
    void'(sb.pop_front());
    n_checks++;
    if (bus.CS !== 1'b0 || bus.LocalAddr !== 10'h000 || bus.Misaligned !== 1'b0 || bus.HitCount !== 16'h0000) begin
      n_fail++; $display("FAIL midreset: got cs=%b ofs=%h mis=%b cnt=%h want all zero",
                         bus.CS, bus.LocalAddr, bus.Misaligned, bus.HitCount);
    end
    apply(32'h0000_0701, 1'b1, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (bus.CS !== 1'b1 || bus.LocalAddr !== 10'h201 || bus.Misaligned !== 1'b1 || bus.HitCount !== e.cnt) begin
      n_fail++; $display("FAIL midreset_resume: got cs=%b ofs=%h mis=%b cnt=%h want 1/201/1/%h",
                         bus.CS, bus.LocalAddr, bus.Misaligned, bus.HitCount, e.cnt);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    apply(32'h0000_0500, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 65535; i++) begin
      apply(32'h0000_0500, 1'b1, 1'b0);
      e = sb.pop_front();
      if (bus.HitCount !== e.cnt) begin
        n_checks++; n_fail++;
        $display("FAIL preload_cnt: got %h want %h", bus.HitCount, e.cnt);
      end
    end
    n_checks++;
    if (bus.HitCount !== 16'hFFFF) begin n_fail++; $display("FAIL preload_max: got %h want ffff", bus.HitCount); end
    for (int i = 0; i < 3; i++) begin
      apply(32'h0000_0600, 1'b1, 1'b0);
      void'(sb.pop_front());
      n_checks++;
      if (bus.HitCount !== 16'hFFFF) begin n_fail++; $display("FAIL saturate: got %h want ffff", bus.HitCount); end
    end
  endtask

  initial begin
    RST           = 1'b1;
    bus.Address   = 32'h0000_0700;
    bus.AddrValid = 1'b1;
    model_cnt     = 16'h0000;
    #1;
    test_reset();
    test_boundary();
    test_sweep();
    test_hitcount();
    test_extremes();
    test_midstream_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
